// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the multicycle sequencer: opcodes/functs, FSM states,
// instruction classes, trap causes, register write-select and next-PC select.
package alu_seq_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BGTE  = 6'h01;
    localparam logic [5:0] OP_BLE   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEQ  = 6'h06;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h14;
    localparam logic [5:0] OP_JAL   = 6'h15;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_JR, C_IALU, C_LW, C_SW, C_BR, C_J, C_JAL, C_HALT, C_ILL
    } iclass_t;

    typedef enum logic [1:0] {TC_NONE, TC_ILLEGAL, TC_IMEM, TC_DMEM} trap_cause_t;
    typedef enum logic [1:0] {WSEL_ALU, WSEL_MEM, WSEL_LINK} rf_wsel_t;
    typedef enum logic [1:0] {PCS_SEQ, PCS_BR, PCS_JMP, PCS_REG} pc_sel_t;

    function automatic iclass_t decode_class(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_SLL, FN_SRL, FN_SLT: return C_RTYPE;
                    FN_JR:                  return C_JR;
                    default:                return C_ILL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI:   return C_IALU;
            OP_LW:                                         return C_LW;
            OP_SW:                                         return C_SW;
            OP_BEQ, OP_BNE, OP_BGT, OP_BGTE, OP_BLE, OP_BLEQ: return C_BR;
            OP_J:                                          return C_J;
            OP_JAL:                                        return C_JAL;
            OP_HALT:                                       return C_HALT;
            default:                                       return C_ILL;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Instruction- and data-memory request/ack bus between the sequencer and memories.
interface alu_seq_ctrl_if #(parameter int AW = 10);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic          dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
        input  imem_ack, imem_rdata, dmem_ack
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/alu_seq_branch_unit.sv
// Signed branch compare and next-PC mux (sequential, branch, jump, register).
module alu_seq_branch_unit
    import alu_seq_ctrl_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic [AW-1:0] pc,
    input  logic [5:0]    opcode,
    input  logic [15:0]   imm,
    input  logic [AW-1:0] jmp_tgt,
    input  logic [31:0]   op_a,
    input  logic [31:0]   op_b,
    input  pc_sel_t       sel,
    output logic [AW-1:0] pc_next
);
    logic signed [31:0] sa, sb;
    logic [AW-1:0]      pc_inc, br_tgt;
    logic               taken;

    assign sa     = op_a;
    assign sb     = op_b;
    assign pc_inc = pc + AW'(1);
    // Offset is sign-extended (or truncated) to the PC width so the target wraps.
    assign br_tgt = pc_inc + AW'($signed(imm));

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = (sa == sb);
            OP_BNE:  taken = (sa != sb);
            OP_BGT:  taken = (sa >  sb);
            OP_BGTE: taken = (sa >= sb);
            OP_BLE:  taken = (sa <  sb);
            OP_BLEQ: taken = (sa <= sb);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_next = pc_inc;
        case (sel)
            PCS_SEQ: pc_next = pc_inc;
            PCS_BR:  pc_next = taken ? br_tgt : pc_inc;
            PCS_JMP: pc_next = jmp_tgt;
            PCS_REG: pc_next = op_a[AW-1:0];
            default: pc_next = pc_inc;
        endcase
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Multicycle fetch/decode/exec/mem/wb sequencer; owns the PC, retire counter
// and the memory handshakes, and traps on illegal opcodes or ack timeouts.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int            AW          = 10,
    parameter logic [AW-1:0] RESET_PC    = '0,
    parameter int            ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    alu_seq_ctrl_if.master        mem,
    output logic [31:0]           instr,
    input  logic [31:0]           op_a,
    input  logic [31:0]           op_b,
    output logic                  alu_en,
    input  logic [31:0]           alu_result,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [1:0]            rf_wsel,
    output logic [AW-1:0]         pc,
    output logic                  halted,
    output logic                  trap,
    output logic [1:0]            trap_cause,
    output logic [31:0]           retired
);
    localparam logic [3:0] TO = 4'(ACK_TIMEOUT);

    state_t        state, state_nxt, retire_to;
    iclass_t       cls;
    pc_sel_t       pc_sel;
    logic          pc_we, retire, set_trap, set_halt;
    trap_cause_t   cause_nxt;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] pc_next;
    logic          unused_alu_hi;

    assign cls           = decode_class(instr[31:26], instr[5:0]);
    assign retire_to     = run ? S_FETCH : S_IDLE;
    assign mem.imem_addr = pc;
    assign unused_alu_hi = ^alu_result[31:AW];

    alu_seq_branch_unit #(.AW(AW)) u_br (
        .pc      (pc),
        .opcode  (instr[31:26]),
        .imm     (instr[15:0]),
        .jmp_tgt (instr[AW-1:0]),
        .op_a    (op_a),
        .op_b    (op_b),
        .sel     (pc_sel),
        .pc_next (pc_next)
    );

    always_comb begin
        state_nxt = state;
        pc_we     = 1'b0;
        pc_sel    = PCS_SEQ;
        retire    = 1'b0;
        set_trap  = 1'b0;
        set_halt  = 1'b0;
        cause_nxt = TC_NONE;
        case (state)
            S_IDLE: if (run) state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem.imem_ack) state_nxt = S_DECODE;
                else if (wait_cnt == TO) begin
                    state_nxt = S_TRAP; set_trap = 1'b1; cause_nxt = TC_IMEM;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_ILL:   begin state_nxt = S_TRAP; set_trap = 1'b1; cause_nxt = TC_ILLEGAL; end
                    C_HALT:  begin state_nxt = S_HALT; set_halt = 1'b1; retire = 1'b1; end
                    default: state_nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_BR:       begin pc_we = 1'b1; pc_sel = PCS_BR;  retire = 1'b1; state_nxt = retire_to; end
                    C_J:        begin pc_we = 1'b1; pc_sel = PCS_JMP; retire = 1'b1; state_nxt = retire_to; end
                    C_JR:       begin pc_we = 1'b1; pc_sel = PCS_REG; retire = 1'b1; state_nxt = retire_to; end
                    C_LW, C_SW: state_nxt = S_MEM;
                    default:    state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem.dmem_ack) begin
                    if (cls == C_SW) begin
                        pc_we = 1'b1; retire = 1'b1; state_nxt = retire_to;
                    end else state_nxt = S_WB;
                end else if (wait_cnt == TO) begin
                    state_nxt = S_TRAP; set_trap = 1'b1; cause_nxt = TC_DMEM;
                end
            end
            S_WB: begin
                pc_we     = 1'b1;
                pc_sel    = (cls == C_JAL) ? PCS_JMP : PCS_SEQ;
                retire    = 1'b1;
                state_nxt = retire_to;
            end
            default: state_nxt = state;
        endcase
    end

    // Strobes are registered from state_nxt so they are high exactly during their state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            instr         <= '0;
            retired       <= '0;
            wait_cnt      <= '0;
            mem.imem_req  <= 1'b0;
            mem.dmem_req  <= 1'b0;
            mem.dmem_we   <= 1'b0;
            mem.dmem_addr <= '0;
            alu_en        <= 1'b0;
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wsel       <= '0;
            halted        <= 1'b0;
            trap          <= 1'b0;
            trap_cause    <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) wait_cnt <= '0;
            else if (wait_cnt != TO) wait_cnt <= wait_cnt + 4'd1;
            if (state == S_FETCH && mem.imem_ack) instr <= mem.imem_rdata;
            if (pc_we) pc <= pc_next;
            retired <= retired + {31'd0, retire};
            mem.imem_req <= (state_nxt == S_FETCH);
            mem.dmem_req <= (state_nxt == S_MEM);
            mem.dmem_we  <= (state_nxt == S_MEM) && (cls == C_SW);
            if (state == S_EXEC) mem.dmem_addr <= alu_result[AW-1:0];
            alu_en   <= (state_nxt == S_EXEC);
            rf_we    <= (state_nxt == S_WB);
            rf_waddr <= (cls == C_JAL) ? 5'd31 : (cls == C_RTYPE) ? instr[15:11] : instr[20:16];
            rf_wsel  <= (cls == C_LW) ? WSEL_MEM : (cls == C_JAL) ? WSEL_LINK : WSEL_ALU;
            if (set_halt) halted <= 1'b1;
            if (set_trap) begin
                trap       <= 1'b1;
                trap_cause <= cause_nxt;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: hand-computed PC/retire/strobe expectations.
module tb_alu_seq_ctrl;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [31:0]   instr, retired;
    logic [31:0]   op_a = '0, op_b = '0, alu_result = '0;
    logic          alu_en, rf_we, halted, trap;
    logic [4:0]    rf_waddr;
    logic [1:0]    rf_wsel, trap_cause;
    logic [AW-1:0] pc;
    int            n_chk = 0, n_fail = 0, rf_we_cnt = 0;

    alu_seq_ctrl_if #(.AW(AW)) mif ();

    alu_seq_ctrl #(.AW(AW), .RESET_PC(10'h10), .ACK_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mem        (mif),
        .instr      (instr),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_en     (alu_en),
        .alu_result (alu_result),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wsel    (rf_wsel),
        .pc         (pc),
        .halted     (halted),
        .trap       (trap),
        .trap_cause (trap_cause),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rf_we === 1'b1) rf_we_cnt++;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) for imem_req, delays dly cycles, then pulses imem_ack with w.
    // Returns at the negedge where the DUT sits in DECODE.
    task automatic fetch(input logic [31:0] w, input int dly, input logic [AW-1:0] exp_pc);
        int k = 0;
        while (mif.imem_req !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("fetch_req", mif.imem_req, 1);
        chk("fetch_addr", mif.imem_addr, exp_pc);
        repeat (dly) @(negedge clk);
        mif.imem_ack   = 1'b1;
        mif.imem_rdata = w;
        @(negedge clk);
        mif.imem_ack   = 1'b0;
        mif.imem_rdata = '0;
    endtask

    initial begin
        int cnt, we0;
        mif.imem_ack = 1'b0; mif.imem_rdata = '0; mif.dmem_ack = 1'b0;
        run = 1'b1;
        step(2);
        chk("rst_pc", pc, 10'h10);
        chk("rst_instr", instr, 0);
        chk("rst_retired", retired, 0);
        chk("rst_strobes", {mif.imem_req, mif.dmem_req, mif.dmem_we, alu_en, rf_we}, 0);
        chk("rst_status", {halted, trap, trap_cause, rf_waddr, rf_wsel}, 0);
        rst_n = 1'b1;

        // add $3,$1,$2 with a 2-cycle fetch latency
        fetch(32'h0022_1820, 2, 10'h10);
        chk("add_instr", instr, 32'h0022_1820);
        step(1); chk("add_alu_en", alu_en, 1);
        step(1); chk("add_wb", {rf_we, rf_waddr, rf_wsel}, {1'b1, 5'd3, 2'd0});
        step(1); chk("add_pc", pc, 10'h11); chk("add_ret", retired, 1);

        fetch(32'h5000_0020, 0, 10'h11);
        step(2); chk("j_pc", pc, 10'h20); chk("j_ret", retired, 2);

        we0 = rf_we_cnt;
        op_a = 32'd5; op_b = 32'd7;
        fetch(32'h1422_FFFE, 1, 10'h20);
        step(2); chk("bne_taken_pc", pc, 10'h1F); chk("bne_ret", retired, 3);
        fetch(32'h5000_0020, 0, 10'h1F);
        step(2); chk("j2_pc", pc, 10'h20);
        op_a = 32'd7; op_b = 32'd7;
        fetch(32'h1422_FFFE, 0, 10'h20);
        step(2); chk("bne_nt_pc", pc, 10'h21); chk("bne_nt_ret", retired, 5);
        chk("br_no_rf_we", rf_we_cnt, we0);

        // lw $2,4($1) with dmem_ack on the fourth MEM cycle
        alu_result = 32'h0000_0104;
        fetch(32'h8C22_0004, 0, 10'h21);
        step(2);
        chk("lw_dmem_addr", mif.dmem_addr, 10'h104);
        cnt = 0;
        repeat (3) begin
            if (mif.dmem_req === 1'b1) cnt++;
            chk("lw_dmem_we", mif.dmem_we, 0);
            step(1);
        end
        if (mif.dmem_req === 1'b1) cnt++;
        mif.dmem_ack = 1'b1;
        step(1);
        mif.dmem_ack = 1'b0;
        chk("lw_req_cycles", cnt, 4);
        chk("lw_req_drop", mif.dmem_req, 0);
        chk("lw_wb", {rf_we, rf_waddr, rf_wsel}, {1'b1, 5'd2, 2'd1});
        step(1); chk("lw_pc", pc, 10'h22); chk("lw_ret", retired, 6);
        chk("lw_refetch", mif.imem_req, 1);

        // sw $2,8($1) acked immediately
        alu_result = 32'h0000_0108;
        fetch(32'hAC22_0008, 0, 10'h22);
        step(2);
        chk("sw_req_we", {mif.dmem_req, mif.dmem_we}, 2'b11);
        mif.dmem_ack = 1'b1;
        step(1);
        mif.dmem_ack = 1'b0;
        chk("sw_pc", pc, 10'h23); chk("sw_ret", retired, 7);

        fetch(32'h5000_0005, 0, 10'h23);
        step(2); chk("j3_pc", pc, 10'h05);

        // jal 0x40 with run dropped mid-instruction
        fetch(32'h5400_0040, 0, 10'h05);
        run = 1'b0;
        step(2); chk("jal_wb", {rf_we, rf_waddr, rf_wsel}, {1'b1, 5'd31, 2'd2});
        step(1); chk("jal_pc", pc, 10'h40); chk("jal_ret", retired, 9);
        cnt = 0;
        repeat (3) begin if (mif.imem_req === 1'b1) cnt++; step(1); end
        chk("idle_no_req", cnt, 0);
        run = 1'b1;

        op_a = 32'h0000_0123;
        fetch(32'h0020_0008, 0, 10'h40);
        step(2); chk("jr_pc", pc, 10'h123); chk("jr_ret", retired, 10);

        fetch(32'hF800_0000, 0, 10'h123);
        step(1);
        chk("ill_trap", {trap, trap_cause}, {1'b1, 2'd1});
        chk("ill_pc", pc, 10'h123); chk("ill_ret", retired, 10);
        cnt = 0;
        repeat (5) begin if (mif.imem_req === 1'b1) cnt++; step(1); end
        chk("trap_no_req", cnt, 0);

        rst_n = 1'b0; step(1); rst_n = 1'b1;
        fetch(32'hFC00_0000, 0, 10'h10);
        step(1);
        chk("halt_status", {halted, trap}, 2'b10);
        chk("halt_pc", pc, 10'h10); chk("halt_ret", retired, 1);
        cnt = 0;
        repeat (3) begin if (mif.imem_req === 1'b1) cnt++; step(1); end
        chk("halt_no_req", cnt, 0);

        // imem_ack withheld
        rst_n = 1'b0; step(1);
        chk("rst2_status", {halted, trap, trap_cause}, 0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (25) begin step(1); if (mif.imem_req === 1'b1) cnt++; end
        chk("to_req_cycles", cnt, 16);
        chk("to_trap", {trap, trap_cause}, {1'b1, 2'd2});

        // async reset while waiting in MEM
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        alu_result = 32'h0000_0104;
        fetch(32'h8C22_0004, 0, 10'h10);
        step(2);
        chk("ar_in_mem", mif.dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_strobes", {mif.imem_req, mif.dmem_req, mif.dmem_we, alu_en, rf_we}, 0);
        chk("ar_pc", pc, 10'h10);
        chk("ar_instr", instr, 0);
        chk("ar_dmem_addr", mif.dmem_addr, 0);
        chk("ar_status", {retired, halted, trap, trap_cause}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
